// File: rtl/aes_key_expand_nch.sv
// aes_key_expand_nch: N-channel time-interleaved AES-128/256 key expander, one tagged round key per cycle.
// Optional build macro AES_KS_ABORT_EN adds an abort input that returns the block to IDLE.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    b    = gf_mul(x252, x2);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign out_o = sbox(in_i);
endmodule

module aes_key_expand_nch #(
  parameter int unsigned N       = 4,
  parameter int unsigned KEY_LEN = 128,
  localparam int unsigned CHW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rstn,
`ifdef AES_KS_ABORT_EN
  input  logic               abort,
`endif
  input  logic               key_vld,
  output logic               key_rdy,
  input  logic [KEY_LEN-1:0] key_in,
  output logic               rk_vld,
  input  logic               rk_rdy,
  output logic [127:0]       rk,
  output logic [CHW-1:0]     rk_ch,
  output logic [3:0]         rk_rnd,
  output logic               busy
);
  localparam int unsigned NR    = (KEY_LEN == 256) ? 14 : 10;
  localparam bit          IS256 = (KEY_LEN == 256);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_e;

  state_e             state_q, state_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [3:0]         rnd_q, rnd_d;
  logic               rdy_en_q;
  logic               rk_vld_q, rk_vld_d;
  logic [127:0]       rk_q, rk_d;
  logic [CHW-1:0]     rk_ch_q, rk_ch_d;
  logic [3:0]         rk_rnd_q, rk_rnd_d;
  logic [KEY_LEN-1:0] ring_q [N];
  logic               ring_we;
  logic [CHW-1:0]     ring_wa;
  logic [KEY_LEN-1:0] ring_wd;

  logic               abort_c;
  logic               out_free_c;
  logic               key_acc_c;
  logic [KEY_LEN-1:0] head_c;
  logic [127:0]       lo4_c;
  logic               rot_c;
  logic               skip_c;
  logic [3:0]         rcon_idx_c;
  logic [31:0]        last_c, sub_in_c, sub_out_c, t_c;
  logic [31:0]        n0_c, n1_c, n2_c, n3_c;
  logic [127:0]       nw_c;
  logic [KEY_LEN-1:0] new_entry_c;

`ifdef AES_KS_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign out_free_c = !rk_vld_q || rk_rdy;
  assign key_rdy    = rdy_en_q && out_free_c && !abort_c && (state_q == IDLE || state_q == LOAD);
  assign key_acc_c  = key_vld && key_rdy;

  // Head-channel expansion step; AES-256 odd rounds skip RotWord and Rcon
  assign head_c     = ring_q[ch_q];
  assign lo4_c      = head_c[KEY_LEN-1 -: 128];
  assign last_c     = head_c[31:0];
  assign rot_c      = !(IS256 && rnd_q[0]);
  assign skip_c     = IS256 && (rnd_q == 4'd1);
  assign rcon_idx_c = IS256 ? (rnd_q >> 1) : rnd_q;
  assign sub_in_c   = rot_c ? {last_c[23:0], last_c[31:24]} : last_c;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sub_in_c[8*i +: 8]),
      .out_o (sub_out_c[8*i +: 8])
    );
  end

  assign t_c  = sub_out_c ^ (rot_c ? {rcon(rcon_idx_c), 24'h000000} : 32'h0);
  assign n0_c = lo4_c[127:96] ^ t_c;
  assign n1_c = lo4_c[95:64]  ^ n0_c;
  assign n2_c = lo4_c[63:32]  ^ n1_c;
  assign n3_c = lo4_c[31:0]   ^ n2_c;
  assign nw_c = {n0_c, n1_c, n2_c, n3_c};

  if (KEY_LEN == 256) begin : g_256
    assign new_entry_c = {head_c[127:0], nw_c};
  end else begin : g_128
    assign new_entry_c = nw_c;
  end

  // Next-state, ring write and output-register logic
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rnd_d    = rnd_q;
    rk_vld_d = rk_vld_q && !rk_rdy;
    rk_d     = rk_q;
    rk_ch_d  = rk_ch_q;
    rk_rnd_d = rk_rnd_q;
    ring_we  = 1'b0;
    ring_wa  = ch_q;
    ring_wd  = new_entry_c;
    if (abort_c) begin
      state_d  = IDLE;
      rk_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_acc_c) begin
            ring_we  = 1'b1;
            ring_wa  = '0;
            ring_wd  = key_in;
            rk_vld_d = 1'b1;
            rk_d     = key_in[KEY_LEN-1 -: 128];
            rk_ch_d  = '0;
            rk_rnd_d = 4'd0;
            if (N == 1) begin
              state_d = EXPAND;
              ch_d    = '0;
              rnd_d   = 4'd1;
            end else begin
              state_d = LOAD;
              ch_d    = CHW'(1);
            end
          end
        end
        LOAD: begin
          if (key_acc_c) begin
            ring_we  = 1'b1;
            ring_wd  = key_in;
            rk_vld_d = 1'b1;
            rk_d     = key_in[KEY_LEN-1 -: 128];
            rk_ch_d  = ch_q;
            rk_rnd_d = 4'd0;
            if (ch_q == CHW'(N - 1)) begin
              state_d = EXPAND;
              ch_d    = '0;
              rnd_d   = 4'd1;
            end else begin
              ch_d = ch_q + CHW'(1);
            end
          end
        end
        EXPAND: begin
          if (out_free_c) begin
            ring_we  = !skip_c;
            rk_vld_d = 1'b1;
            rk_d     = skip_c ? head_c[127:0] : nw_c;
            rk_ch_d  = ch_q;
            rk_rnd_d = rnd_q;
            if (ch_q == CHW'(N - 1)) begin
              ch_d = '0;
              if (rnd_q == 4'(NR)) begin
                state_d = IDLE;
                rnd_d   = 4'd0;
              end else begin
                rnd_d = rnd_q + 4'd1;
              end
            end else begin
              ch_d = ch_q + CHW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      rnd_q    <= 4'd0;
      rdy_en_q <= 1'b0;
      rk_vld_q <= 1'b0;
      rk_q     <= '0;
      rk_ch_q  <= '0;
      rk_rnd_q <= 4'd0;
      for (int i = 0; i < N; i++) ring_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rnd_q    <= rnd_d;
      rdy_en_q <= 1'b1;
      rk_vld_q <= rk_vld_d;
      rk_q     <= rk_d;
      rk_ch_q  <= rk_ch_d;
      rk_rnd_q <= rk_rnd_d;
      if (ring_we) ring_q[ring_wa] <= ring_wd;
    end
  end

  assign rk_vld = rk_vld_q;
  assign rk     = rk_q;
  assign rk_ch  = rk_ch_q;
  assign rk_rnd = rk_rnd_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_aes_key_expand_nch.sv
// Directed bench for aes_key_expand_nch: AES-128/256 single channel, 4-channel interleave,
// backpressure, mid-run reset and (with AES_KS_ABORT_EN) abort, against FIPS-197 key schedules.

module tb_aes_key_expand_nch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // A: N=1 AES-128, B: N=1 AES-256, C: N=4 AES-128
  logic         a_key_vld, a_key_rdy, a_rk_vld, a_rk_rdy, a_busy;
  logic [127:0] a_key_in, a_rk;
  logic [0:0]   a_rk_ch;
  logic [3:0]   a_rk_rnd;
  logic         b_key_vld, b_key_rdy, b_rk_vld, b_rk_rdy, b_busy;
  logic [255:0] b_key_in;
  logic [127:0] b_rk;
  logic [0:0]   b_rk_ch;
  logic [3:0]   b_rk_rnd;
  logic         c_key_vld, c_key_rdy, c_rk_vld, c_rk_rdy, c_busy;
  logic [127:0] c_key_in, c_rk;
  logic [1:0]   c_rk_ch;
  logic [3:0]   c_rk_rnd;
`ifdef AES_KS_ABORT_EN
  logic a_abort, b_abort, c_abort;
`endif

  aes_key_expand_nch #(.N(1), .KEY_LEN(128)) dut_a (
    .clk(clk), .rstn(rstn),
`ifdef AES_KS_ABORT_EN
    .abort(a_abort),
`endif
    .key_vld(a_key_vld), .key_rdy(a_key_rdy), .key_in(a_key_in),
    .rk_vld(a_rk_vld), .rk_rdy(a_rk_rdy), .rk(a_rk), .rk_ch(a_rk_ch),
    .rk_rnd(a_rk_rnd), .busy(a_busy)
  );

  aes_key_expand_nch #(.N(1), .KEY_LEN(256)) dut_b (
    .clk(clk), .rstn(rstn),
`ifdef AES_KS_ABORT_EN
    .abort(b_abort),
`endif
    .key_vld(b_key_vld), .key_rdy(b_key_rdy), .key_in(b_key_in),
    .rk_vld(b_rk_vld), .rk_rdy(b_rk_rdy), .rk(b_rk), .rk_ch(b_rk_ch),
    .rk_rnd(b_rk_rnd), .busy(b_busy)
  );

  aes_key_expand_nch #(.N(4), .KEY_LEN(128)) dut_c (
    .clk(clk), .rstn(rstn),
`ifdef AES_KS_ABORT_EN
    .abort(c_abort),
`endif
    .key_vld(c_key_vld), .key_rdy(c_key_rdy), .key_in(c_key_in),
    .rk_vld(c_rk_vld), .rk_rdy(c_rk_rdy), .rk(c_rk), .rk_ch(c_rk_ch),
    .rk_rnd(c_rk_rnd), .busy(c_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] mem_a [16];
  logic [127:0] mem_b [16];
  logic [127:0] mem_c [6][44];
  logic [127:0] keys_c [4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load four keys into C and collect accepted round keys into mem_c[run]
  task automatic run_c(input bit bp, input int stop_rnd, input int run);
    int           kidx, nacc;
    bit           rdy, pv, prdy, stop;
    logic [127:0] prk;
    logic [1:0]   pch;
    logic [3:0]   prnd;
    kidx = 0; nacc = 0; pv = 1'b0; prdy = 1'b1; stop = 1'b0;
    prk = '0; pch = '0; prnd = '0;
    for (int c = 0; c < 600 && nacc < 44 && !stop; c++) begin
      @(negedge clk);
      if (pv && !prdy) begin
        chk("c_hold_vld", 128'(c_rk_vld), 128'(1'b1));
        chk("c_hold_rk", c_rk, prk);
        chk("c_hold_ch", 128'(c_rk_ch), 128'(pch));
        chk("c_hold_rnd", 128'(c_rk_rnd), 128'(prnd));
      end
      rdy       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      c_rk_rdy  = rdy;
      c_key_vld = (kidx < 4);
      c_key_in  = keys_c[(kidx < 4) ? kidx : 0];
      #1;
      if (c_key_vld && c_key_rdy) kidx++;
      if (kidx == 4 && nacc >= 4 && nacc < 40)
        chk("c_key_rdy_expand", 128'(c_key_rdy), 128'(1'b0));
      if (c_rk_vld && rdy) begin
        chk("c_ch_seq", 128'(c_rk_ch), 128'(nacc % 4));
        chk("c_rnd_seq", 128'(c_rk_rnd), 128'(nacc / 4));
        mem_c[run][nacc] = c_rk;
        if (stop_rnd >= 0 && int'(c_rk_rnd) == stop_rnd) stop = 1'b1;
        nacc++;
      end
      pv = c_rk_vld; prdy = rdy; prk = c_rk; pch = c_rk_ch; prnd = c_rk_rnd;
    end
    c_key_vld = 1'b0;
    if (stop_rnd < 0) chk("c_count", 128'(nacc), 128'(44));
    else chk("c_stop_reached", 128'(stop), 128'(1'b1));
  endtask

  task automatic check_c(input int run);
    chk("c_ch2_r0",  mem_c[run][2],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("c_ch3_r0",  mem_c[run][3],  128'h000102030405060708090a0b0c0d0e0f);
    chk("c_ch0_r1",  mem_c[run][4],  128'h62636363626363636263636362636363);
    chk("c_ch1_r1",  mem_c[run][5],  128'he8e9e9e917161616e8e9e9e917161616);
    chk("c_ch2_r1",  mem_c[run][6],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("c_ch3_r1",  mem_c[run][7],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("c_ch0_r10", mem_c[run][40], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("c_ch2_r10", mem_c[run][42], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("c_ch3_r10", mem_c[run][43], 128'h13111d7fe3944a17f307a78b4d2b30c5);
  endtask

  initial begin
    int  nv;
    bit  done;
    keys_c[0] = 128'h0;
    keys_c[1] = {128{1'b1}};
    keys_c[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keys_c[3] = 128'h000102030405060708090a0b0c0d0e0f;
    rstn = 1'b0;
    a_key_vld = 0; a_key_in = '0; a_rk_rdy = 0;
    b_key_vld = 0; b_key_in = '0; b_rk_rdy = 0;
    c_key_vld = 0; c_key_in = '0; c_rk_rdy = 0;
`ifdef AES_KS_ABORT_EN
    a_abort = 0; b_abort = 0; c_abort = 0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_key_rdy", 128'(c_key_rdy), 128'(1'b0));
    chk("rst_rk_vld", 128'(c_rk_vld), 128'(1'b0));
    chk("rst_rk", c_rk, 128'h0);
    chk("rst_rk_ch", 128'(c_rk_ch), 128'(0));
    chk("rst_rk_rnd", 128'(c_rk_rnd), 128'(0));
    chk("rst_busy", 128'(c_busy), 128'(1'b0));
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_key_rdy", 128'(c_key_rdy), 128'(1'b1));

    // AES-128, N=1
    a_key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c; a_key_vld = 1'b1; a_rk_rdy = 1'b1;
    #1 chk("a_key_rdy", 128'(a_key_rdy), 128'(1'b1));
    @(negedge clk);
    a_key_vld = 1'b0;
    nv = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (a_rk_vld && nv < 16) begin
        chk("a_rnd_seq", 128'(a_rk_rnd), 128'(nv));
        mem_a[nv] = a_rk;
        nv++;
      end else done = 1'b1;
    end
    chk("a_consecutive", 128'(nv), 128'(11));
    chk("a_r0", mem_a[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("a_r1", mem_a[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a_r2", mem_a[2], 128'hf2c295f27a96b9435935807a7359f67f);
    chk("a_r10", mem_a[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("a_busy_end", 128'(a_busy), 128'(1'b0));

    // AES-256, N=1
    b_key_in = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    b_key_vld = 1'b1; b_rk_rdy = 1'b1;
    #1 chk("b_key_rdy", 128'(b_key_rdy), 128'(1'b1));
    @(negedge clk);
    b_key_vld = 1'b0;
    nv = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (b_rk_vld && nv < 16) begin
        chk("b_rnd_seq", 128'(b_rk_rnd), 128'(nv));
        mem_b[nv] = b_rk;
        nv++;
      end else done = 1'b1;
    end
    chk("b_consecutive", 128'(nv), 128'(15));
    chk("b_r0", mem_b[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("b_r1", mem_b[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("b_r2", mem_b[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("b_r3", mem_b[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    chk("b_r14", mem_b[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Four channels, no stall then random backpressure
    run_c(1'b0, -1, 0);
    check_c(0);
    run_c(1'b1, -1, 1);
    check_c(1);

    // Reset in the middle of round 5
    run_c(1'b1, 5, 2);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_rk_vld", 128'(c_rk_vld), 128'(1'b0));
    chk("mid_rst_rk", c_rk, 128'h0);
    chk("mid_rst_rk_ch", 128'(c_rk_ch), 128'(0));
    chk("mid_rst_rk_rnd", 128'(c_rk_rnd), 128'(0));
    chk("mid_rst_busy", 128'(c_busy), 128'(1'b0));
    chk("mid_rst_key_rdy", 128'(c_key_rdy), 128'(1'b0));
    c_rk_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_no_out", 128'(c_rk_vld), 128'(1'b0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rel_no_out", 128'(c_rk_vld), 128'(1'b0));
    run_c(1'b0, -1, 3);
    check_c(3);

`ifdef AES_KS_ABORT_EN
    run_c(1'b0, 3, 4);
    c_abort = 1'b1;
    @(negedge clk);
    c_abort = 1'b0;
    chk("abort_rk_vld", 128'(c_rk_vld), 128'(1'b0));
    chk("abort_busy", 128'(c_busy), 128'(1'b0));
    #1 chk("abort_key_rdy", 128'(c_key_rdy), 128'(1'b1));
    run_c(1'b0, -1, 5);
    check_c(5);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
